// File: rtl/qpsk_pkg.sv
// Shared definitions for the QPSK transmit path: sequencer states, the idle
// symbol and the sync byte the receiver correlator also searches for.
package qpsk_pkg;

   typedef enum logic [1:0] {
      IDLE,
      PREAMBLE,
      SYNC,
      PAYLOAD
   } state_t;

   localparam logic [1:0] SYM_IDLE          = 2'b00;
   localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hD3;

endpackage

// File: rtl/qpsk_sym_timer.sv
// Symbol period timer: counts SPS clocks per symbol and flags the last clock
// of each period so the controller can load the next symbol on that edge.
// While disabled it parks at the reload value, so a period always starts
// full-length on the first enabled clock.
module qpsk_sym_timer #(
   parameter int SPS = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic i_en,
   output logic o_sym_end
);

   localparam int            CW     = $clog2(SPS) + 1;
   localparam logic [CW-1:0] RELOAD = CW'(SPS - 1);
   localparam logic [CW-1:0] ONE    = CW'(1);

   logic [CW-1:0] r_cnt;

   // Down-count through the symbol period, reloading at zero or when disabled
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt <= RELOAD;
      end else if (!i_en || (r_cnt == '0)) begin
         r_cnt <= RELOAD;
      end else begin
         r_cnt <= r_cnt - ONE;
      end
   end

   assign o_sym_end = i_en && (r_cnt == '0);

endmodule

// File: rtl/qpsk_tx_ctrl.sv
// QPSK transmit frame sequencer: emits preamble, sync byte and payload bytes
// as 2-bit symbols (MSB pair first), each held for SPS clocks, pulling
// payload through a one-byte holding register on a valid/ready stream.
module qpsk_tx_ctrl
   import qpsk_pkg::*;
#(
   parameter int         SPS           = 4,
   parameter int         PREAMBLE_SYMS = 8,
   parameter logic [7:0] SYNC_BYTE     = SYNC_BYTE_DEFAULT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       i_start,
   input  logic [7:0] i_frame_len,
   input  logic [7:0] i_byte_data,
   input  logic       i_byte_valid,
   output logic       o_byte_ready,
   output logic [1:0] o_sym_out,
   output logic       o_sym_en,
   output logic       o_busy,
   output logic       o_done,
   output logic       o_underrun
);

   localparam int            PW     = $clog2(PREAMBLE_SYMS + 1);
   localparam logic [PW-1:0] PW_ONE = PW'(1);
   localparam logic [PW-1:0] PW_END = PW'(PREAMBLE_SYMS);

   state_t        r_state;
   logic [PW-1:0] r_pre_cnt;
   logic [1:0]    r_sym_idx;
   logic [7:0]    r_len;
   logic [7:0]    r_fetched;
   logic [7:0]    r_sent;
   logic [7:0]    r_hold;
   logic          r_hold_full;
   logic [7:0]    r_shift;
   logic [1:0]    r_sym_out;
   logic          r_sym_en;
   logic          r_busy;
   logic          r_done;
   logic          r_underrun;

   logic          w_sym_end;
   logic          w_byte_ready;
   logic          w_xfer;
   logic          w_more;
   logic [8:0]    w_sent_inc;

   qpsk_sym_timer #(
      .SPS (SPS)
   ) u_sym_timer (
      .clk       (clk),
      .reset     (reset),
      .i_en      (r_busy),
      .o_sym_end (w_sym_end)
   );

   assign w_byte_ready = (r_state != IDLE) && !r_hold_full && (r_fetched < r_len);
   assign w_xfer       = i_byte_valid && w_byte_ready;
   assign w_sent_inc   = {1'b0, r_sent} + 9'd1;
   // Whether another payload byte follows the byte (or sync) now finishing
   assign w_more       = (r_state == SYNC) ? (r_len != 8'd0)
                                           : (w_sent_inc < {1'b0, r_len});

   // Frame sequencer: state, counters, holding/shift registers and outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= IDLE;
         r_pre_cnt   <= '0;
         r_sym_idx   <= 2'd0;
         r_len       <= 8'd0;
         r_fetched   <= 8'd0;
         r_sent      <= 8'd0;
         r_hold      <= 8'd0;
         r_hold_full <= 1'b0;
         r_shift     <= 8'd0;
         r_sym_out   <= SYM_IDLE;
         r_sym_en    <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_underrun  <= 1'b0;
      end else begin
         r_sym_en   <= 1'b0;
         r_done     <= 1'b0;
         r_underrun <= 1'b0;

         if (w_xfer) begin
            r_hold      <= i_byte_data;
            r_hold_full <= 1'b1;
            r_fetched   <= r_fetched + 8'd1;
         end

         case (r_state)
            IDLE: begin
               if (i_start) begin
                  r_state     <= PREAMBLE;
                  r_len       <= i_frame_len;
                  r_fetched   <= 8'd0;
                  r_sent      <= 8'd0;
                  r_hold_full <= 1'b0;
                  r_pre_cnt   <= PW_ONE;
                  r_sym_out   <= SYM_IDLE;
                  r_sym_en    <= 1'b1;
                  r_busy      <= 1'b1;
               end
            end

            PREAMBLE: begin
               if (w_sym_end) begin
                  r_sym_en <= 1'b1;
                  if (r_pre_cnt == PW_END) begin
                     r_state   <= SYNC;
                     r_sym_idx <= 2'd0;
                     r_sym_out <= SYNC_BYTE[7:6];
                     r_shift   <= {SYNC_BYTE[5:0], 2'b00};
                  end else begin
                     r_sym_out <= r_pre_cnt[0] ? 2'b11 : 2'b00;
                     r_pre_cnt <= r_pre_cnt + PW_ONE;
                  end
               end
            end

            SYNC, PAYLOAD: begin
               if (w_sym_end) begin
                  if (r_sym_idx != 2'd3) begin
                     r_sym_out <= r_shift[7:6];
                     r_shift   <= {r_shift[5:0], 2'b00};
                     r_sym_idx <= r_sym_idx + 2'd1;
                     r_sym_en  <= 1'b1;
                  end else begin
                     if (r_state == PAYLOAD) begin
                        r_sent <= r_sent + 8'd1;
                     end
                     if (w_more && r_hold_full) begin
                        r_state     <= PAYLOAD;
                        r_sym_out   <= r_hold[7:6];
                        r_shift     <= {r_hold[5:0], 2'b00};
                        r_hold_full <= 1'b0;
                        r_sym_idx   <= 2'd0;
                        r_sym_en    <= 1'b1;
                     end else begin
                        // Either the frame is complete or the next byte never arrived
                        r_state    <= IDLE;
                        r_busy     <= 1'b0;
                        r_sym_out  <= SYM_IDLE;
                        r_done     <= !w_more;
                        r_underrun <= w_more;
                     end
                  end
               end
            end

            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign o_byte_ready = w_byte_ready;
   assign o_sym_out    = r_sym_out;
   assign o_sym_en     = r_sym_en;
   assign o_busy       = r_busy;
   assign o_done       = r_done;
   assign o_underrun   = r_underrun;

endmodule

// File: tb/tb_qpsk_tx_ctrl.sv
// Bench for qpsk_tx_ctrl: two instances (SPS=4/PREAMBLE=4 and SPS=1/PREAMBLE=8)
// driven through directed and randomized frames, every cycle compared with a
// symbol-list reference model of the frame.
module tb_qpsk_tx_ctrl;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset;
   logic       start;
   logic       sel;
   logic       byte_valid;
   logic [7:0] frame_len;
   logic [7:0] byte_data;
   logic       start4, start1;

   logic       rdy4, sen4, busy4, done4, und4;
   logic [1:0] sym4;
   logic       rdy1, sen1, busy1, done1, und1;
   logic [1:0] sym1;

   assign start4 = start & ~sel;
   assign start1 = start & sel;

   qpsk_tx_ctrl #(.SPS(4), .PREAMBLE_SYMS(4), .SYNC_BYTE(8'hD3)) dut4 (
      .clk          (clk),
      .reset        (reset),
      .i_start      (start4),
      .i_frame_len  (frame_len),
      .i_byte_data  (byte_data),
      .i_byte_valid (byte_valid),
      .o_byte_ready (rdy4),
      .o_sym_out    (sym4),
      .o_sym_en     (sen4),
      .o_busy       (busy4),
      .o_done       (done4),
      .o_underrun   (und4)
   );

   qpsk_tx_ctrl #(.SPS(1), .PREAMBLE_SYMS(8), .SYNC_BYTE(8'hD3)) dut1 (
      .clk          (clk),
      .reset        (reset),
      .i_start      (start1),
      .i_frame_len  (frame_len),
      .i_byte_data  (byte_data),
      .i_byte_valid (byte_valid),
      .o_byte_ready (rdy1),
      .o_sym_out    (sym1),
      .o_sym_en     (sen1),
      .o_busy       (busy1),
      .o_done       (done1),
      .o_underrun   (und1)
   );

   // {ready, busy, sym_en, sym_out[1:0], done, underrun}
   logic [6:0] obs4, obs1, obs;
   assign obs4 = {rdy4, busy4, sen4, sym4, done4, und4};
   assign obs1 = {rdy1, busy1, sen1, sym1, done1, und1};
   assign obs  = sel ? obs1 : obs4;

   int         total = 0;
   int         bad   = 0;
   logic [7:0] bytes [0:255];

   task automatic check(input string tag, input int k, input logic [6:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, k, obs, exp);
      end
   endtask

   task automatic check_idle(input string tag, input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         start      = 1'b0;
         byte_valid = ($urandom_range(0, 1) == 1);
         byte_data  = 8'($urandom);
         @(negedge clk);
         check(tag, i, 7'b0);
      end
      byte_valid = 1'b0;
   endtask

   // One frame: n payload bytes, avail of them ever offered by the source.
   // b2b starts in the current (done) cycle; repulse_k re-pulses start at
   // that cycle; abort_k stops checking after that cycle (0 = never).
   task automatic run_frame(input string tag, input int n, input bit b2b,
                            input int avail, input bit rnd_valid,
                            input int repulse_k, input int abort_k);
      int         sps, pre, ttot, xfers, consumed, s, j, nxt;
      bit         pend, fin, first, rdy;
      logic [1:0] q[$];
      logic [7:0] t, sync_b;
      logic [6:0] exp;

      sps    = sel ? 1 : 4;
      pre    = sel ? 8 : 4;
      ttot   = (pre + 4 + 4 * n) * sps;
      sync_b = 8'hD3;
      q      = {};
      for (int i = 0; i < pre; i++) q.push_back((i % 2 == 1) ? 2'b11 : 2'b00);
      for (int i = 3; i >= 0; i--) begin
         t = sync_b >> (2 * i);
         q.push_back(t[1:0]);
      end
      for (int b = 0; b < n; b++) begin
         for (int i = 3; i >= 0; i--) begin
            t = bytes[b] >> (2 * i);
            q.push_back(t[1:0]);
         end
      end

      if (!b2b) begin
         @(posedge clk);
         #1;
      end
      start      = 1'b1;
      frame_len  = 8'(n);
      byte_valid = 1'b0;
      xfers      = 0;
      consumed   = 0;
      pend       = 1'b0;
      fin        = 1'b0;

      for (int k = 1; !fin; k++) begin
         @(posedge clk);
         #1;
         start      = (k == repulse_k);
         frame_len  = 8'($urandom);
         nxt        = xfers + int'(pend);
         byte_valid = (nxt < avail) && (rnd_valid ? ($urandom_range(0, 1) == 1) : 1'b1);
         byte_data  = (nxt < n) ? bytes[nxt] : 8'($urandom);
         @(negedge clk);

         rdy = 1'b0;
         if (k <= ttot) begin
            s     = (k - 1) / sps;
            first = ((k - 1) % sps) == 0;
            exp   = {1'b0, 1'b1, first, q[s], 1'b0, 1'b0};
            if (first && (s >= pre + 4) && (((s - pre - 4) % 4) == 0)) begin
               j = (s - pre - 4) / 4;
               // bytes delivered at least one edge earlier must cover byte j
               if (xfers <= j) begin
                  exp = 7'b0000001;
                  fin = 1'b1;
               end else begin
                  consumed = j + 1;
               end
            end
            xfers += int'(pend);
            pend   = 1'b0;
            rdy    = !fin && (xfers == consumed) && (xfers < n);
            exp[6] = rdy;
         end else begin
            exp = 7'b0000010;
            fin = 1'b1;
         end
         check(tag, k, exp);
         pend = rdy && byte_valid;
         if (k == abort_k) fin = 1'b1;
      end
      start      = 1'b0;
      byte_valid = 1'b0;
   endtask

   initial begin
      int n, av;
      sel        = 1'b0;
      reset      = 1'b1;
      start      = 1'b0;
      byte_valid = 1'b0;
      frame_len  = 8'd0;
      byte_data  = 8'd0;

      // Reset values on both instances
      #1;
      check("reset_sps4", 0, 7'b0);
      sel = 1'b1;
      #1;
      check("reset_sps1", 0, 7'b0);
      sel = 1'b0;
      #10;
      reset = 1'b0;
      check_idle("idle_after_reset", 2);

      // Directed frame: A5, 3C
      bytes[0] = 8'hA5;
      bytes[1] = 8'h3C;
      run_frame("frame_a5_3c", 2, 1'b0, 2, 1'b0, 0, 0);
      check_idle("idle_after_a5", 1);

      // Empty payload
      run_frame("frame_len0", 0, 1'b0, 0, 1'b0, 0, 0);
      check_idle("idle_after_len0", 1);

      // Underrun: only the first byte ever supplied
      bytes[0] = 8'h96;
      bytes[1] = 8'h0F;
      run_frame("underrun", 2, 1'b0, 1, 1'b0, 0, 0);
      check_idle("idle_after_underrun", 2);

      // start re-pulsed mid-frame, then a new start in the done cycle
      for (int i = 0; i < 3; i++) bytes[i] = 8'($urandom);
      run_frame("repulse", 3, 1'b0, 3, 1'b0, 20, 0);
      bytes[0] = 8'($urandom);
      run_frame("start_in_done", 1, 1'b1, 1, 1'b0, 0, 0);
      check_idle("idle_after_b2b", 1);

      // Reset in the middle of payload with the next byte already held
      bytes[0] = 8'hE7;
      bytes[1] = 8'h81;
      run_frame("pre_reset", 2, 1'b0, 2, 1'b0, 0, 40);
      #2;
      reset = 1'b1;
      #1;
      check("reset_async", 0, 7'b0);
      @(posedge clk);
      #2;
      reset = 1'b0;
      check_idle("idle_after_midreset", 1);
      bytes[0] = 8'h5A;
      bytes[1] = 8'hC3;
      run_frame("after_reset", 2, 1'b0, 2, 1'b0, 0, 0);
      check_idle("idle_after_reset_frame", 1);

      // SPS=1: continuous byte stream, then randomized valid gaps
      sel = 1'b1;
      check_idle("idle_sps1", 1);
      for (int i = 0; i < 8; i++) bytes[i] = 8'($urandom);
      run_frame("sps1_stream", 8, 1'b0, 8, 1'b0, 0, 0);
      for (int r = 0; r < 3; r++) begin
         n = $urandom_range(1, 6);
         for (int i = 0; i < n; i++) bytes[i] = 8'($urandom);
         run_frame("sps1_random", n, 1'b0, n, 1'b1, 0, 0);
         check_idle("idle_sps1_random", 1);
      end

      // SPS=4: random lengths, gaps and partial supply
      sel = 1'b0;
      for (int r = 0; r < 4; r++) begin
         n  = $urandom_range(0, 4);
         av = (r == 3) ? $urandom_range(0, n) : n;
         for (int i = 0; i < n; i++) bytes[i] = 8'($urandom);
         run_frame("sps4_random", n, 1'b0, av, 1'b1, 0, 0);
         check_idle("idle_sps4_random", 1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/qpsk_tx_ctrl.md
# qpsk_tx_ctrl

Transmit-side frame sequencer that feeds the QPSK symbol mapper. It accepts payload bytes over a valid/ready stream and prepends a preamble and a sync byte to each frame. Bytes are split into 2-bit symbols, MSB pair first, and each symbol is held for SPS clocks. The 2-bit symbol output connects directly to the mapper's data input, and a per-symbol strobe is provided for downstream pulse shaping.

## Interface
- SPS, 4: clocks per symbol (≥1); symbol counter width is $clog2(SPS)+1.
- PREAMBLE_SYMS, 8: number of preamble symbols (≥1), alternating 2'b00, 2'b11, starting with 2'b00.
- SYNC_BYTE, 8'hD3: sync byte sent after the preamble.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- start  in  1  one-cycle frame request; ignored while busy.
- frame_len  in  8  payload byte count, sampled with start; 0 is legal.
- byte_data  in  8  payload byte.
- byte_valid  in  1  byte_data valid.
- byte_ready  out  1  controller accepts a byte this cycle.
- sym_out  out  2  symbol to the mapper; 2'b00 when idle.
- sym_en  out  1  one-cycle pulse on the first clock of each symbol.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse on normal frame completion.
- underrun  out  1  one-cycle pulse when a frame is aborted for lack of data.

## Operation
- States:
  - IDLE → PREAMBLE on start.
  - PREAMBLE → SYNC after PREAMBLE_SYMS symbols.
  - SYNC → PAYLOAD after 4 symbols, or → IDLE with done if frame_len=0.
  - PAYLOAD → IDLE after 4·frame_len symbols (done), or on underrun.
- Symbol order within a byte: [7:6], [5:4], [3:2], [1:0].
- One-byte holding register:
  - byte_ready = state≠IDLE && holding empty && bytes_fetched < frame_len.
  - A transfer occurs when byte_valid && byte_ready. Prefetch is allowed from the first PREAMBLE cycle onward.
- Holding register is consumed at the symbol boundary that starts a byte's first payload symbol. The byte then moves to a shift register, and the holding register frees in that same cycle.
- Underrun: a payload byte's first-symbol boundary arrives with the holding register empty.
  - Pulse underrun, return to IDLE, sym_out=2'b00, sym_en=0, no done.
- Counters: 8-bit bytes_fetched and bytes_sent, 2-bit symbol index, preamble counter sized for PREAMBLE_SYMS.
- A start asserted while busy is ignored. frame_len is registered only on an accepted start.

## Timing
- Reset values: byte_ready=0, sym_out=2'b00, sym_en=0, busy=0, done=0, underrun=0. State is IDLE and the holding register is empty.
- Reset mid-frame aborts immediately with no done or underrun pulse. A byte held in the holding register is discarded.
- start sampled at edge T:
  - busy=1 and the first sym_en occur at T+1.
  - sym_out changes only on sym_en cycles and is held for exactly SPS clocks.
- Frame of N bytes: (PREAMBLE_SYMS+4+4N)·SPS busy cycles.
  - done pulses in the cycle after the last symbol period ends.
  - busy=0 and sym_out=2'b00 in that same cycle.
- SPS=1: sym_en is high every busy cycle. The byte path must sustain a byte every 4 clocks with no bubbles.
- A new start is accepted in the done cycle or any later cycle.

## Structure
- Shared package qpsk_pkg holds:
  - the state enum (IDLE, PREAMBLE, SYNC, PAYLOAD);
  - the SYM_IDLE=2'b00 constant;
  - the default SYNC_BYTE constant, so the receiver correlator uses the same value.
- Sub-module qpsk_sym_timer: SPS-cycle down-counter, enable input, sym_en output. It restarts cleanly on enable assertion.

## Test plan
- Normal frame, SPS=4, PREAMBLE_SYMS=4, frame_len=2, bytes A5,3C, start at cycle 0:
  - sym_out sequence 00 11 00 11 | 11 01 00 11 | 10 10 01 01 | 00 11 11 00;
  - sym_en at cycles 1,5,…,61; done at cycle 65; busy low at 65.
- frame_len=0: preamble and sync only. byte_ready never asserts. done at cycle (PREAMBLE_SYMS+4)·SPS+1.
- Underrun, frame_len=2: first byte supplied, second never valid.
  - underrun pulses at the boundary for byte 2's first symbol; no done; busy=0 next cycle.
- start re-pulsed mid-frame: no effect on sequence or timing. start in the done cycle: new frame begins the next cycle.
- Reset asserted mid-PAYLOAD:
  - all outputs 0 asynchronously;
  - a subsequent start yields a full correct frame;
  - the stale held byte never appears.
- SPS=1, byte_valid held high, frame_len=8, random bytes: contiguous symbols match the bytes MSB-first with no underrun.
